// File: rtl/ifu_fetch_pkg.sv
// Shared constants and types for the ifu_fetch instruction fetch front end.
package ifu_fetch_pkg;

  localparam int unsigned GRLEN = 32;
  localparam logic [GRLEN-1:0] INST_BYTES = 32'd4;

  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_REQ  = 2'd1,
    IFU_DROP = 2'd2
  } ifu_state_e;

  typedef struct packed {
    logic [GRLEN-1:0] pc;
    logic [GRLEN-1:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/ifu_fetch_queue.sv
// fetch_queue: small synchronous FIFO with flush; head entry visible combinationally.
module fetch_queue #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && (count != '0) && !flush;
  assign head    = mem[rptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= push_data;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_no_push_full: assert property (@(posedge clk) disable iff (!resetn)
    !(push && !flush && count == FULL));
`endif

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: fetch PC, single-outstanding bus request FSM and redirect handling.
// Optional perf counters are enabled by defining IFU_PERF_CNT_EN.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [GRLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned      FQ_DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  output logic             inst_req,
  output logic [GRLEN-1:0] inst_addr,
  input  logic             inst_valid,
  input  logic [GRLEN-1:0] inst_rdata,
  input  logic             redirect_valid,
  input  logic [GRLEN-1:0] redirect_pc,
  output logic             fe_valid,
  output logic [GRLEN-1:0] fe_pc,
  output logic [GRLEN-1:0] fe_inst,
  input  logic             fe_ready
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]      perf_fetch_cnt,
  output logic [31:0]      perf_drop_cnt
`endif
);

  localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;
  localparam logic [CW-1:0] FQ_FULL = CW'(FQ_DEPTH);
  localparam logic [CW-1:0] FQ_LAST = CW'(FQ_DEPTH - 1);

  ifu_state_e       state;
  logic [GRLEN-1:0] fetch_pc;
  logic [GRLEN-1:0] req_addr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_after_pop;
  fq_entry_t        head;
  fq_entry_t        push_entry;
  logic             pop;
  logic             push;
  logic             drop;

  assign fe_valid        = (count != '0);
  assign fe_pc           = head.pc;
  assign fe_inst         = head.inst;
  assign inst_addr       = req_addr;
  assign pop             = fe_valid && fe_ready && !redirect_valid;
  assign count_after_pop = count - {{(CW-1){1'b0}}, pop};
  assign push            = (state == IFU_REQ) && inst_valid && !redirect_valid;
  assign drop            = inst_valid &&
                           (((state == IFU_REQ) && redirect_valid) || (state == IFU_DROP));
  assign push_entry      = '{pc: req_addr, inst: inst_rdata};

  fetch_queue #(
    .WIDTH (2*GRLEN),
    .DEPTH (FQ_DEPTH)
  ) u_fq (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .head      (head)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IFU_IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      inst_req <= 1'b0;
    end else begin
      if (redirect_valid) fetch_pc <= redirect_pc;
      unique case (state)
        IFU_IDLE: begin
          // A redirect flushes the queue, so a slot is guaranteed this cycle.
          if (redirect_valid || (count_after_pop < FQ_FULL)) begin
            state    <= IFU_REQ;
            inst_req <= 1'b1;
            req_addr <= redirect_valid ? redirect_pc : fetch_pc;
          end
        end
        IFU_REQ: begin
          if (redirect_valid) begin
            // An issued request cannot be retracted: wait for its data in DROP.
            if (inst_valid) req_addr <= redirect_pc;
            else            state    <= IFU_DROP;
          end else if (inst_valid) begin
            fetch_pc <= req_addr + INST_BYTES;
            if (count_after_pop < FQ_LAST) begin
              req_addr <= req_addr + INST_BYTES;
            end else begin
              state    <= IFU_IDLE;
              inst_req <= 1'b0;
            end
          end
        end
        IFU_DROP: begin
          if (inst_valid) begin
            state    <= IFU_REQ;
            req_addr <= redirect_valid ? redirect_pc : fetch_pc;
          end
        end
        default: begin
          state    <= IFU_IDLE;
          inst_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_fetch_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      if (push) perf_fetch_cnt <= perf_fetch_cnt + 1'b1;
      if (drop) perf_drop_cnt  <= perf_drop_cnt + 1'b1;
    end
  end
`endif

`ifndef SYNTHESIS
  a_no_rsp_idle: assert property (@(posedge clk) disable iff (!resetn)
    !((state == IFU_IDLE) && inst_valid));
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: transaction-level model with a randomized bus slave.
`timescale 1ns/1ps
module tb_ifu_fetch;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_valid = 1'b0;
  logic [31:0] inst_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fe_valid;
  logic [31:0] fe_pc;
  logic [31:0] fe_inst;
  logic        fe_ready = 1'b0;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_drop_cnt;
`endif

  always #5 clk = ~clk;

  ifu_fetch #(
    .RESET_PC (RPC),
    .FQ_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_valid     (inst_valid),
    .inst_rdata     (inst_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fe_valid       (fe_valid),
    .fe_pc          (fe_pc),
    .fe_inst        (fe_inst),
    .fe_ready       (fe_ready)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_drop_cnt  (perf_drop_cnt)
`endif
  );

  // Model: buffered {pc,inst} entries, one bus request that may be doomed by a redirect.
  logic [63:0] mq[$];
  bit          m_busy;
  bit          m_doomed;
  logic [31:0] m_req;
  logic [31:0] m_next;
  int unsigned m_pushed;
  int unsigned m_dropped;

  int          nvec = 0;
  int          nerr = 0;
  int unsigned lat_min = 3;
  int unsigned lat_max = 3;
  int unsigned slave_cnt = 0;
  bit          redir_on_valid = 1'b0;
  logic [31:0] redir_on_valid_pc = '0;
  logic [31:0] popped_pc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("inst_req", 32'(inst_req), 32'(m_busy));
    chk("inst_addr", inst_addr, m_req);
    chk("fe_valid", 32'(fe_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("fe_pc", fe_pc, mq[0][63:32]);
      chk("fe_inst", fe_inst, mq[0][31:0]);
    end
`ifdef IFU_PERF_CNT_EN
    chk("perf_fetch_cnt", perf_fetch_cnt, m_pushed);
    chk("perf_drop_cnt", perf_drop_cnt, m_dropped);
`endif
  endtask

  // Called at a negedge: drive one cycle of inputs, advance the model, compare at next negedge.
  task automatic tick(input bit rdy, input bit rv, input logic [31:0] rpc);
    bit          v;
    logic [31:0] data;
    v = 1'b0;
    if (!m_busy) slave_cnt = $urandom_range(lat_max, lat_min);
    else if (slave_cnt == 0) begin
      v = 1'b1;
      slave_cnt = $urandom_range(lat_max, lat_min);
    end else slave_cnt--;
    if (v && redir_on_valid) begin
      rv = 1'b1;
      rpc = redir_on_valid_pc;
      redir_on_valid = 1'b0;
    end
    data = $urandom;
    inst_valid     = v;
    inst_rdata     = data;
    redirect_valid = rv;
    redirect_pc    = rpc;
    fe_ready       = rdy;
    if (rdy && fe_valid && !rv) popped_pc.push_back(fe_pc);

    if (rv) m_next = rpc;
    if (rv) mq.delete();
    else if (rdy && mq.size() != 0) void'(mq.pop_front());
    if (!m_busy) begin
      if (mq.size() < DEPTH) begin
        m_busy = 1'b1;
        m_doomed = 1'b0;
        m_req = m_next;
      end
    end else if (m_doomed) begin
      if (v) begin
        m_dropped++;
        m_doomed = 1'b0;
        m_req = m_next;
      end
    end else if (v) begin
      if (rv) begin
        m_dropped++;
        m_req = rpc;
      end else begin
        mq.push_back({m_req, data});
        m_pushed++;
        m_next = m_req + 32'd4;
        if (mq.size() < DEPTH) m_req = m_req + 32'd4;
        else m_busy = 1'b0;
      end
    end else if (rv) m_doomed = 1'b1;

    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    inst_valid = 1'b0;
    inst_rdata = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    fe_ready = 1'b0;
    #1;
    chk("rst inst_req", 32'(inst_req), 32'd0);
    chk("rst inst_addr", inst_addr, RPC);
    chk("rst fe_valid", 32'(fe_valid), 32'd0);
    chk("rst fe_pc", fe_pc, 32'd0);
    chk("rst fe_inst", fe_inst, 32'd0);
    repeat (2) @(posedge clk);
    mq.delete();
    popped_pc.delete();
    m_busy = 1'b0;
    m_doomed = 1'b0;
    m_req = RPC;
    m_next = RPC;
    m_pushed = 0;
    m_dropped = 0;
    redir_on_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    compare();
  endtask

  task automatic wait_for_addr(input logic [31:0] a, input bit rdy, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (inst_req && inst_addr == a) begin
        ok = 1'b1;
        return;
      end
      tick(rdy, 1'b0, '0);
    end
  endtask

  initial begin
    bit ok;
    bit rv;

    // Back-to-back fetch with a fixed 3-cycle bus latency and decode always ready.
    lat_min = 3; lat_max = 3;
    do_reset();
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, '0);
    chk("p1 pop0 pc", popped_pc[0], 32'h0);
    chk("p1 pop1 pc", popped_pc[1], 32'h4);
    chk("p1 pop2 pc", popped_pc[2], 32'h8);

    // Decode stalled: exactly DEPTH fetches, then idle; one pop frees the fetch of 0x10.
    lat_min = 1; lat_max = 1;
    do_reset();
    for (int i = 0; i < 30; i++) tick(1'b0, 1'b0, '0);
    chk("p2 idle req", 32'(inst_req), 32'd0);
    chk("p2 head pc", fe_pc, 32'h0);
    chk("p2 model depth", mq.size(), 32'd4);
    tick(1'b1, 1'b0, '0);
    wait_for_addr(32'h10, 1'b0, 10, ok);
    chk("p2 wait 0x10", 32'(ok), 32'd1);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, '0);
    chk("p2 refill idle", 32'(inst_req), 32'd0);
    chk("p2 refill head", fe_pc, 32'h4);

    // Redirect while the request for 0x8 is outstanding.
    lat_min = 3; lat_max = 3;
    do_reset();
    wait_for_addr(32'h8, 1'b1, 40, ok);
    chk("p3 wait 0x8", 32'(ok), 32'd1);
    tick(1'b1, 1'b1, 32'h100);
    chk("p3 flushed", 32'(fe_valid), 32'd0);
    chk("p3 req held", 32'(inst_req), 32'd1);
    chk("p3 addr held", inst_addr, 32'h8);
    wait_for_addr(32'h100, 1'b1, 20, ok);
    chk("p3 wait 0x100", 32'(ok), 32'd1);
    chk("p3 empty", 32'(fe_valid), 32'd0);
    chk("p3 model drops", m_dropped, 32'd1);

    // Redirect coinciding with the response.
    redir_on_valid = 1'b1;
    redir_on_valid_pc = 32'h200;
    for (int i = 0; i < 20 && redir_on_valid; i++) tick(1'b1, 1'b0, '0);
    chk("p4 applied", 32'(redir_on_valid), 32'd0);
    chk("p4 addr", inst_addr, 32'h200);
    chk("p4 empty", 32'(fe_valid), 32'd0);

    // Two redirects while draining a doomed request.
    lat_min = 5; lat_max = 5;
    tick(1'b1, 1'b1, 32'h300);
    tick(1'b1, 1'b1, 32'h400);
    wait_for_addr(32'h400, 1'b1, 20, ok);
    chk("p5 wait 0x400", 32'(ok), 32'd1);
    chk("p5 model drops", m_dropped, 32'd3);

    // Randomized traffic.
    lat_min = 0; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      rv = ($urandom_range(99, 0) < 3);
      tick($urandom_range(99, 0) < 70, rv, $urandom & 32'hFFFF_FFFC);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
